rr_arbiter8: RTL and testbench
==============================

RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 SHALL provide parameter MAX_HOLD, default 4: maximum consecutive cycles one requester may hold a grant (legal range 1..15).
REQ-002 SHALL provide port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL provide port en, input, 1: arbitration enable.
REQ-005 SHALL provide port req, input, 8: request vector; bit i = requester i.
REQ-006 SHALL provide port gnt, output, 8: one-hot grant vector, all-zero when no grant.
REQ-007 SHALL provide port gnt_idx, output, 3: binary index of the granted requester.
REQ-008 SHALL provide port gnt_valid, output, 1: high while a grant is active.

Function
REQ-009 SHALL implement states IDLE (no grant) and GRANT (one grant active).
REQ-010 SHALL hold a 3-bit round-robin pointer ptr: the highest-priority index, searched upward with wrap from 7 to 0.
REQ-011 SHALL, in IDLE with en=1 and req!=0, select the first set req bit at or after ptr and enter GRANT at the next edge, giving 1-cycle latency from req sample to gnt.
REQ-012 SHALL, on each new grant to index k, set ptr to (k+1) mod 8 and load hold_cnt to 1.
REQ-013 SHALL, in GRANT, increment hold_cnt each cycle that req[gnt_idx]=1, en=1 and hold_cnt<MAX_HOLD, keeping the grant.
REQ-014 SHALL end the grant at the next edge when req[gnt_idx]=0 or hold_cnt=MAX_HOLD.
REQ-015 SHALL, when a grant ends with en=1 and any other req bit set, grant the next requester from the updated ptr at that same edge, with no idle bubble.
REQ-016 SHALL, if only the just-released requester is still requesting at the end of a grant, re-grant it, since it is the sole candidate.
REQ-017 SHALL, when en=0 in GRANT, clear the grant and enter IDLE at the next edge; ptr is unchanged.
REQ-018 SHALL, when en=0 in IDLE, issue no grants.
REQ-019 SHALL drive gnt combinationally from registered gnt_idx and gnt_valid: gnt = one-hot(gnt_idx) when gnt_valid=1, else 8'h00.
REQ-020 SHALL never assert more than one gnt bit in any cycle.
REQ-021 SHALL treat req changes on non-granted bits mid-grant as having no effect until the next arbitration point.

Reset
REQ-022 SHALL, on rst_n low, asynchronously force state=IDLE, ptr=0, hold_cnt=0, gnt_idx=0, gnt_valid=0 and gnt=8'h00.
REQ-023 SHALL, on reset assertion mid-grant, drop gnt immediately without waiting for a clock edge.
REQ-024 SHALL treat the first edge after rst_n deasserts as a normal IDLE arbitration cycle.

Configuration
REQ-025 SHALL use macro RR_ARBITER8_LOCK_EN; when defined, grants are held per REQ-013/014 (lock up to MAX_HOLD).
REQ-026 SHALL, when RR_ARBITER8_LOCK_EN is undefined, limit every grant to exactly one cycle.
- Arbitration happens every cycle among pending requests.
- hold_cnt is not implemented.
- MAX_HOLD is ignored.

Structure
REQ-027 SHALL place the following in shared package arb_pkg:
- NUM_REQ=8 and IDX_W=3.
- State enum arb_state_t {IDLE, GRANT}.
- HOLD_W=4.
REQ-028 SHALL instantiate the existing decoder3_8 sub-module to produce gnt from gnt_idx, with gnt_valid as its enable.

Verification
REQ-029 SHALL cover reset: rst_n=0 mid-grant -> gnt=8'h00 and gnt_valid=0 asynchronously; then ptr=0 and the first grant goes to the lowest set bit.
REQ-030 SHALL cover round robin (lock off or MAX_HOLD=1): req=8'hFF held -> gnt sequence 01,02,04,...,80,01 on consecutive cycles.
REQ-031 SHALL cover hold limit (lock on, MAX_HOLD=4): req=8'h05 held -> gnt=01 for 4 cycles, then 04 for 4 cycles, then 01, with no bubbles.
REQ-032 SHALL cover early release (lock on): req=8'h09 with gnt=01, then req[0] dropped after 2 cycles -> gnt=08 at the next edge with gnt_idx=3.
REQ-033 SHALL cover enable: en dropped while gnt=04 -> gnt=00 at the next edge; en raised with req=8'h14 -> gnt=10 (ptr=3).
REQ-034 SHALL cover the sole requester: req=8'h20 only, lock on, MAX_HOLD=2 -> gnt=20 continuously, with hold_cnt reloading to 1 every 2 cycles.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
// Provides the requester/index widths, the FSM state type and the priority search.
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;
    localparam int HOLD_W  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Lowest set bit at or above ptr wins; otherwise wrap to the lowest set bit overall.
    function automatic pick_t pick_next(input logic [NUM_REQ-1:0] req,
                                        input logic [IDX_W-1:0]   ptr);
        pick_t              res;
        logic [NUM_REQ-1:0] upper;
        upper     = req & ~((NUM_REQ'(1) << ptr) - NUM_REQ'(1));
        res.found = 1'b0;
        res.idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                res.found = 1'b1;
                res.idx   = IDX_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (upper[i]) begin
                res.idx = IDX_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/decoder3_8.sv
// 3-to-8 one-hot decoder with enable; output is all-zero when disabled.
module decoder3_8
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0]   idx_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] dec_o
);

    always_comb begin
        dec_o = '0;
        if (en_i) begin
            dec_o = NUM_REQ'(1) << idx_i;
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with a registered grant index and combinational one-hot grant.
// Define RR_ARBITER8_LOCK_EN to let a requester hold its grant for up to MAX_HOLD cycles.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : gBadMaxHold
        $error("rr_arbiter8: MAX_HOLD must be in 1..15");
    end

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    pick_t            pick;
    logic             keepGrant;

    assign pick = pick_next(req, ptr_q);

`ifdef RR_ARBITER8_LOCK_EN
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

    logic [HOLD_W-1:0] hold_q, hold_d;

    assign keepGrant = req[idx_q] && (hold_q < HOLD_LIMIT);

    // hold_cnt restarts at 1 on every new grant and counts while the holder keeps the grant.
    always_comb begin
        hold_d = hold_q;
        if (state_d == GRANT && (state_q == IDLE || !keepGrant)) begin
            hold_d = HOLD_W'(1);
        end else if (state_q == GRANT && en && keepGrant) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign keepGrant = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (en && pick.found) begin
                    state_d = GRANT;
                    idx_d   = pick.idx;
                    valid_d = 1'b1;
                    ptr_d   = pick.idx + IDX_W'(1);
                end
            end
            GRANT: begin
                if (!en) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else if (!keepGrant) begin
                    // Release point: re-arbitrate at once so a waiting requester sees no bubble.
                    if (pick.found) begin
                        idx_d = pick.idx;
                        ptr_d = pick.idx + IDX_W'(1);
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;

    decoder3_8 uDecoder (
        .idx_i (idx_q),
        .en_i  (valid_q),
        .dec_o (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: vector table, directed corner sequences and a random run
// against a behavioural model. Follows the RR_ARBITER8_LOCK_EN setting used for the RTL build.
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 4;
`ifdef RR_ARBITER8_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic [7:0] expGnt;
        logic       expValid;
        logic [2:0] expIdx;
    } vecRec_t;

    vecRec_t vecs[12];

    int mValid;
    int mIdx;
    int mPtr;
    int mHold;

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs, let the rising edge take them, then sample just after it.
    task automatic applyStimulus(input logic enIn, input logic [7:0] reqIn);
        en  = enIn;
        req = reqIn;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expGnt,
                               input logic expValid, input logic [2:0] expIdx);
        logic bad;
        nCompared++;
        bad = (gnt !== expGnt) || (gnt_valid !== expValid) || (expValid && (gnt_idx !== expIdx));
        if (bad) begin
            nMismatched++;
            $display("[TB] FAIL %s: got gnt=%h valid=%b idx=%0d, expected gnt=%h valid=%b idx=%0d",
                     name, gnt, gnt_valid, gnt_idx, expGnt, expValid, expIdx);
        end
    endtask

    // Leaves the bench on a falling edge with reset released and inputs idle.
    task automatic doReset();
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;
        #1;
        checkOutput("reset_state", 8'h00, 1'b0, 3'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic modelReset();
        mValid = 0;
        mIdx   = 0;
        mPtr   = 0;
        mHold  = 0;
    endtask

    function automatic int modelPick(input logic [7:0] r, input int p);
        for (int off = 0; off < 8; off++) begin
            if (r[(p + off) % 8]) return (p + off) % 8;
        end
        return -1;
    endfunction

    task automatic modelGrant(input int k);
        mValid = 1;
        mIdx   = k;
        mPtr   = (k + 1) % 8;
        mHold  = 1;
    endtask

    task automatic modelStep(input logic e, input logic [7:0] r);
        int k;
        k = modelPick(r, mPtr);
        if (mValid == 0) begin
            if (e && k >= 0) modelGrant(k);
        end else if (!e) begin
            mValid = 0;
        end else if (LOCK_ON && r[mIdx] && mHold < MAX_HOLD) begin
            mHold++;
        end else if (k >= 0) begin
            modelGrant(k);
        end else begin
            mValid = 0;
        end
    endtask

    initial begin
        logic [7:0] seqExp;
        logic [7:0] rReq;
        logic       rEn;
        logic [7:0] mGnt;

        rst_n = 1'b1;
        en    = 1'b0;
        req   = 8'h00;

`ifdef RR_ARBITER8_LOCK_EN
        vecs[0]  = '{1'b1, 8'h00, 8'h00, 1'b0, 3'd0};
        vecs[1]  = '{1'b1, 8'h0A, 8'h02, 1'b1, 3'd1};
        vecs[2]  = '{1'b1, 8'h0A, 8'h02, 1'b1, 3'd1};
        vecs[3]  = '{1'b1, 8'h08, 8'h08, 1'b1, 3'd3};
        vecs[4]  = '{1'b1, 8'h08, 8'h08, 1'b1, 3'd3};
        vecs[5]  = '{1'b1, 8'h08, 8'h08, 1'b1, 3'd3};
        vecs[6]  = '{1'b1, 8'h08, 8'h08, 1'b1, 3'd3};
        vecs[7]  = '{1'b1, 8'h08, 8'h08, 1'b1, 3'd3};
        vecs[8]  = '{1'b0, 8'h08, 8'h00, 1'b0, 3'd0};
        vecs[9]  = '{1'b1, 8'h11, 8'h10, 1'b1, 3'd4};
        vecs[10] = '{1'b1, 8'h00, 8'h00, 1'b0, 3'd0};
        vecs[11] = '{1'b1, 8'h01, 8'h01, 1'b1, 3'd0};
`else
        vecs[0]  = '{1'b1, 8'h00, 8'h00, 1'b0, 3'd0};
        vecs[1]  = '{1'b1, 8'h0A, 8'h02, 1'b1, 3'd1};
        vecs[2]  = '{1'b1, 8'h0A, 8'h08, 1'b1, 3'd3};
        vecs[3]  = '{1'b1, 8'h0A, 8'h02, 1'b1, 3'd1};
        vecs[4]  = '{1'b1, 8'h81, 8'h80, 1'b1, 3'd7};
        vecs[5]  = '{1'b1, 8'h81, 8'h01, 1'b1, 3'd0};
        vecs[6]  = '{1'b0, 8'hFF, 8'h00, 1'b0, 3'd0};
        vecs[7]  = '{1'b1, 8'h01, 8'h01, 1'b1, 3'd0};
        vecs[8]  = '{1'b1, 8'h01, 8'h01, 1'b1, 3'd0};
        vecs[9]  = '{1'b1, 8'h00, 8'h00, 1'b0, 3'd0};
        vecs[10] = '{1'b1, 8'h40, 8'h40, 1'b1, 3'd6};
        vecs[11] = '{1'b1, 8'hC0, 8'h80, 1'b1, 3'd7};
`endif

        $display("[TB] vector table");
        doReset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].en, vecs[i].req);
            checkOutput($sformatf("vec%0d", i), vecs[i].expGnt, vecs[i].expValid, vecs[i].expIdx);
        end

        $display("[TB] asynchronous reset mid-grant");
        doReset();
        applyStimulus(1'b1, 8'h30);
        checkOutput("pre_reset_grant", 8'h10, 1'b1, 3'd4);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_drop", 8'h00, 1'b0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'h0C);
        checkOutput("post_reset_lowest", 8'h04, 1'b1, 3'd2);

        $display("[TB] enable drop and raise");
        doReset();
        applyStimulus(1'b1, 8'h04);
        checkOutput("en_grant04", 8'h04, 1'b1, 3'd2);
        applyStimulus(1'b0, 8'h04);
        checkOutput("en_low_clear", 8'h00, 1'b0, 3'd0);
        applyStimulus(1'b0, 8'h14);
        checkOutput("en_low_idle", 8'h00, 1'b0, 3'd0);
        applyStimulus(1'b1, 8'h14);
        checkOutput("en_high_ptr3", 8'h10, 1'b1, 3'd4);

`ifdef RR_ARBITER8_LOCK_EN
        $display("[TB] hold limit");
        doReset();
        for (int i = 0; i < 9; i++) begin
            seqExp = (i < 4 || i == 8) ? 8'h01 : 8'h04;
            applyStimulus(1'b1, 8'h05);
            checkOutput($sformatf("hold_c%0d", i), seqExp, 1'b1, (seqExp == 8'h01) ? 3'd0 : 3'd2);
        end

        $display("[TB] early release");
        doReset();
        applyStimulus(1'b1, 8'h09);
        checkOutput("early_c0", 8'h01, 1'b1, 3'd0);
        applyStimulus(1'b1, 8'h09);
        checkOutput("early_c1", 8'h01, 1'b1, 3'd0);
        applyStimulus(1'b1, 8'h08);
        checkOutput("early_next", 8'h08, 1'b1, 3'd3);

        $display("[TB] sole requester");
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'h20);
            checkOutput($sformatf("sole_c%0d", i), 8'h20, 1'b1, 3'd5);
        end
`else
        $display("[TB] round robin over all requesters");
        doReset();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 8'hFF);
            checkOutput($sformatf("rr_c%0d", i), 8'h01 << (i % 8), 1'b1, 3'(i % 8));
        end
`endif

        $display("[TB] random run against model");
        doReset();
        modelReset();
        rReq = 8'h00;
        for (int c = 0; c < 1500; c++) begin
            rEn = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 3))
                0:       rReq = 8'($urandom);
                1:       rReq = 8'($urandom) & 8'($urandom);
                2:       rReq = (8'h01 << $urandom_range(0, 7));
                default: ;
            endcase
            if ($urandom_range(0, 15) == 0) rReq = 8'h00;
            applyStimulus(rEn, rReq);
            modelStep(rEn, rReq);
            mGnt = (mValid != 0) ? (8'h01 << mIdx) : 8'h00;
            checkOutput($sformatf("rand_c%0d", c), mGnt, (mValid != 0), 3'(mIdx));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
